// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stalls, redirect flushes,
// EX operand forwarding selects and saturating performance counters.
module pipe_hazard_ctrl #(
  parameter int REDIRECT_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemRead,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_RegWrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_RegWrite,
  input  logic             cnt_clr,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             busy_redirect,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, REDIR} state_t;

  state_t     state, state_nxt;
  logic [3:0] rcnt, rcnt_nxt;
  logic       lu_hazard;

  assign lu_hazard = ex_MemRead && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // Outputs are qualified by rst_n so an async reset mid-redirect drops flushes at once.
  always_comb begin
    state_nxt     = state;
    rcnt_nxt      = rcnt;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    busy_redirect = 1'b0;
    if (rst_n) begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (REDIRECT_CYCLES > 1) begin
              state_nxt = REDIR;
              rcnt_nxt  = 4'(REDIRECT_CYCLES - 1);
            end
          end else if (lu_hazard) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        REDIR: begin
          flush_if_id   = 1'b1;
          flush_id_ex   = 1'b1;
          busy_redirect = 1'b1;
          rcnt_nxt      = rcnt - 4'd1;
          if (rcnt == 4'd1) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Operand 0 is A (ex_rs1), operand 1 is B (ex_rs2); EX/MEM wins over MEM/WB.
  logic [1:0][4:0] ex_src;
  logic [1:0][1:0] fwd;
  assign ex_src = {ex_rs2, ex_rs1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    always_comb begin
      fwd[g] = 2'b00;
      if (rst_n) begin
        if (mem_RegWrite && (mem_rd != 5'd0) && (mem_rd == ex_src[g]))
          fwd[g] = 2'b01;
        else if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == ex_src[g]))
          fwd[g] = 2'b10;
      end
    end
  end

  assign fwd_a = fwd[0];
  assign fwd_b = fwd[1];

  logic [2:0][CNT_W-1:0] cnt;
  logic [2:0]            cnt_inc;
  assign cnt_inc = {flush_if_id, stall_pc, 1'b1};

  for (genvar g = 0; g < 3; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          cnt[g] <= '0;
      else if (cnt_clr)                    cnt[g] <= '0;
      else if (cnt_inc[g] && (cnt[g] != '1)) cnt[g] <= cnt[g] + 1'b1;
    end
  end

  assign cyc_cnt   = cnt[0];
  assign stall_cnt = cnt[1];
  assign flush_cnt = cnt[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl with a queue-based scoreboard.
module tb_pipe_hazard_ctrl;
  localparam int RC    = 3;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2;
    logic       use1, use2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       mr, redir;
    logic [4:0] mem_rd;
    logic       mrw;
    logic [4:0] wb_rd;
    logic       wrw, clr, rst;
  } stim_t;

  typedef struct packed {
    logic          spc, sif, fif, fie;
    logic [1:0]    fa, fb;
    logic          busy;
    logic [CW-1:0] cyc, stl, fl;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
  logic [4:0] mem_rd = '0, wb_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_MemRead = 0, ex_redirect = 0;
  logic mem_RegWrite = 0, wb_RegWrite = 0, cnt_clr = 0;
  logic stall_pc, stall_if_id, flush_if_id, flush_id_ex, busy_redirect;
  logic [1:0] fwd_a, fwd_b;
  logic [CW-1:0] cyc_cnt, stall_cnt, flush_cnt;

  pipe_hazard_ctrl #(.REDIRECT_CYCLES(RC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_MemRead(ex_MemRead),
    .ex_redirect(ex_redirect), .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
    .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .cnt_clr(cnt_clr),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .busy_redirect(busy_redirect), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  // Reference model: remaining flush cycles after the current one, plus counter values.
  int m_rem = 0, m_cyc = 0, m_stl = 0, m_fl = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] src, input stim_t s);
    if (s.mrw && s.mem_rd != 0 && s.mem_rd == src) return 2'b01;
    if (s.wrw && s.wb_rd != 0 && s.wb_rd == src)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e = '0;
    logic lu;
    if (!s.rst) return e;
    lu = s.mr && s.ex_rd != 0 &&
         ((s.use1 && s.id_rs1 == s.ex_rd) || (s.use2 && s.id_rs2 == s.ex_rd));
    if (m_rem > 0) begin
      e.fif = 1; e.fie = 1; e.busy = 1;
    end else if (s.redir) begin
      e.fif = 1; e.fie = 1;
    end else if (lu) begin
      e.spc = 1; e.sif = 1; e.fie = 1;
    end
    e.fa  = ref_fwd(s.ex_rs1, s);
    e.fb  = ref_fwd(s.ex_rs2, s);
    e.cyc = m_cyc[CW-1:0];
    e.stl = m_stl[CW-1:0];
    e.fl  = m_fl[CW-1:0];
    return e;
  endfunction

  function automatic int sat_inc(input int v, input bit en);
    return (en && v < CMAX) ? v + 1 : v;
  endfunction

  task automatic model_step(input stim_t s, input exp_t e);
    if (!s.rst) begin
      m_rem = 0; m_cyc = 0; m_stl = 0; m_fl = 0;
      return;
    end
    if (s.clr) begin
      m_cyc = 0; m_stl = 0; m_fl = 0;
    end else begin
      m_cyc = sat_inc(m_cyc, 1'b1);
      m_stl = sat_inc(m_stl, e.spc);
      m_fl  = sat_inc(m_fl, e.fif);
    end
    if (m_rem > 0)    m_rem = m_rem - 1;
    else if (s.redir) m_rem = RC - 1;
  endtask

  // Inputs change 1 time unit after posedge, so rst_n changes are asynchronous.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2; id_use_rs1 = s.use1; id_use_rs2 = s.use2;
    ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd; ex_MemRead = s.mr;
    ex_redirect = s.redir; mem_rd = s.mem_rd; mem_RegWrite = s.mrw;
    wb_rd = s.wb_rd; wb_RegWrite = s.wrw; cnt_clr = s.clr; rst_n = s.rst;
    e = model_out(s);
    sb.push_back(e);
    model_step(s, e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall_pc",      int'(stall_pc),      int'(e.spc));
        chk("stall_if_id",   int'(stall_if_id),   int'(e.sif));
        chk("flush_if_id",   int'(flush_if_id),   int'(e.fif));
        chk("flush_id_ex",   int'(flush_id_ex),   int'(e.fie));
        chk("fwd_a",         int'(fwd_a),         int'(e.fa));
        chk("fwd_b",         int'(fwd_b),         int'(e.fb));
        chk("busy_redirect", int'(busy_redirect), int'(e.busy));
        chk("cyc_cnt",       int'(cyc_cnt),       int'(e.cyc));
        chk("stall_cnt",     int'(stall_cnt),     int'(e.stl));
        chk("flush_cnt",     int'(flush_cnt),     int'(e.fl));
      end
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  initial begin : stim
    stim_t s;
    s = '0;
    repeat (3) drive(s);                       // reset held low
    repeat (2) drive(idle());
    // load-use, then same with x0 destination
    s = idle(); s.mr = 1; s.ex_rd = 5; s.id_rs1 = 5; s.use1 = 1;
    drive(s); drive(idle());
    s.ex_rd = 0; s.id_rs1 = 0;
    drive(s); drive(idle());
    // redirect pulse, second redirect during REDIR ignored
    s = idle(); s.redir = 1;
    drive(s); drive(s); drive(idle()); drive(idle());
    // redirect together with load-use
    s = idle(); s.redir = 1; s.mr = 1; s.ex_rd = 9; s.id_rs2 = 9; s.use2 = 1;
    drive(s); repeat (3) drive(idle());
    // forwarding priority
    s = idle(); s.ex_rs1 = 7; s.mem_rd = 7; s.wb_rd = 7; s.mrw = 1; s.wrw = 1;
    s.ex_rs2 = 7;
    drive(s);
    s.mrw = 0;
    drive(s);
    s.ex_rs2 = 0; s.wb_rd = 0;
    drive(s);
    // saturation and clear
    repeat (20) drive(idle());
    s = idle(); s.clr = 1;
    drive(s); drive(idle());
    // reset mid-REDIR
    s = idle(); s.redir = 1;
    drive(s);
    s = '0;
    drive(s);
    repeat (3) drive(idle());
    // random traffic with narrow register range to provoke collisions
    for (int i = 0; i < 2000; i++) begin
      s.id_rs1 = 5'($urandom_range(0, 7));
      s.id_rs2 = 5'($urandom_range(0, 7));
      s.use1   = 1'($urandom);
      s.use2   = 1'($urandom);
      s.ex_rs1 = 5'($urandom_range(0, 7));
      s.ex_rs2 = 5'($urandom_range(0, 7));
      s.ex_rd  = 5'($urandom_range(0, 7));
      s.mr     = 1'($urandom);
      s.redir  = ($urandom_range(0, 7) == 0);
      s.mem_rd = 5'($urandom_range(0, 7));
      s.mrw    = 1'($urandom);
      s.wb_rd  = 5'($urandom_range(0, 7));
      s.wrw    = 1'($urandom);
      s.clr    = ($urandom_range(0, 49) == 0);
      s.rst    = ($urandom_range(0, 199) != 0);
      drive(s);
    end
    repeat (2) @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
